legv8_regfile: RTL and testbench
================================

Name: legv8_regfile

Overview:
- Architectural register file and NZCV flag register for the LEGv8 datapath.
- Sits directly upstream of the ALU: read port A drives the ALU A operand and read port B drives the ALU B operand. B is also the shift-amount source.
- Captures the ALU 4-bit status vector {V, C, N, Z} when the current instruction sets flags.
- Holds 31 general registers X0..X30; X31 is the zero register XZR.

Parameters:
- DATA_W, 64, register and data-path width in bits.
- ADDR_W, 5, register address width; the register count is 2**ADDR_W.
- ZERO_REG, 31, index that always reads zero and ignores writes.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- SA  input  ADDR_W  read address, port A.
- SB  input  ADDR_W  read address, port B.
- DA  input  ADDR_W  write address.
- D  input  DATA_W  write data.
- W  input  1  write enable.
- A  output  DATA_W  read data, port A; feeds ALU A.
- B  output  DATA_W  read data, port B; feeds ALU B.
- status_in  input  4  ALU status {V, C, N, Z}.
- SL  input  1  status load enable.
- status  output  4  registered NZCV, ordered {V, C, N, Z}.
- cond  input  4  LEGv8 B.cond condition code.
- cond_true  output  1  cond evaluated against the registered status.

Behaviour:
- Reset (synchronous, active-high):
  - Sampled only at the rising clock edge. All 32 entries clear to 0 and status clears to 4'b0000.
  - reset has priority over W and SL in the same cycle.
  - After reset, A = B = 0 for all addresses. cond_true follows the evaluation with NZCV = 0000 (for example EQ = 0, NE = 1, AL = 1).
- Write:
  - On the rising edge with W = 1 and DA != ZERO_REG, entry[DA] <= D.
  - W = 1 with DA = ZERO_REG is a no-op.
  - W = 0 leaves all entries unchanged.
- Read:
  - Combinational, zero-cycle latency from SA/SB.
  - If SA = ZERO_REG then A = 0; likewise SB = ZERO_REG gives B = 0.
- Write-through bypass:
  - If W = 1, DA != ZERO_REG and SA == DA, then A = D in the same cycle, before the edge. The same rule applies to SB and B.
  - The bypass and the ZERO_REG check are both required; ZERO_REG never bypasses.
- Both ports reading the same address is legal; A and B show identical values.
- Status:
  - On the rising edge with SL = 1, status <= status_in.
  - With SL = 0, status holds.
  - status is not bypassed: cond_true reflects the registered value only.
- cond_true (combinational from status and cond), with N = status[1], Z = status[0], C = status[2], V = status[3]:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 HS: C
  - 3 LO: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C & !Z
  - 9 LS: !(C & !Z)
  - 10 GE: N == V
  - 11 LT: N != V
  - 12 GT: !Z & (N == V)
  - 13 LE: !(!Z & (N == V))
  - 14, 15 AL: 1
- Simultaneous events:
  - A write and an SL update in the same cycle both take effect.
  - reset in the middle of a write sequence discards that cycle's write and status load.
- Widths:
  - No truncation or extension is performed.
  - Addresses use all ADDR_W bits; out-of-range addresses cannot occur.

Test Plan:
- Reset: assert reset for one edge after writing X5 = 64'hDEAD_BEEF -> SA = 5 gives A = 0, status = 0000, cond = 1 (NE) gives cond_true = 1.
- Write/read: write X3 = 64'h0123_4567_89AB_CDEF and X30 = 64'hFFFF_FFFF_FFFF_FFFF on consecutive edges; SA = 3, SB = 30 -> A = 64'h0123_4567_89AB_CDEF, B = all-ones; SA = SB = 3 -> both equal 64'h0123_4567_89AB_CDEF.
- XZR: write W = 1, DA = 31, D = 64'h55 -> SA = 31 gives A = 0, before and after the edge; no other entry changes.
- Bypass: X7 holds 64'h10; drive W = 1, DA = 7, D = 64'h20, SA = 7 -> A = 64'h20 before the edge, and still 64'h20 after the edge with W = 0. With SB = 8 in the same cycle, B is unaffected.
- Status and conditions: SL = 1, status_in = {V, C, N, Z} = 4'b0010 (N only) -> LT = 1, GE = 0, MI = 1. With SL = 0, status_in = 4'b0001 -> status unchanged. Then SL = 1 with 4'b0101 (C and Z) -> EQ = 1, HI = 0, LS = 1, GT = 0, AL = 1.
- Reset priority: same edge has reset = 1, W = 1 (DA = 2, D = 64'h99), SL = 1 (status_in = 4'b1111) -> X2 = 0 and status = 0000 after the edge.

Source files
------------

// File: rtl/legv8_regfile.sv
// LEGv8 architectural register file with write-through bypass, XZR handling,
// and the NZCV status register with B.cond evaluation.
module legv8_regfile #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] SA,
  input  logic [ADDR_W-1:0] SB,
  input  logic [ADDR_W-1:0] DA,
  input  logic [DATA_W-1:0] D,
  input  logic              W,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  input  logic [3:0]        status_in,
  input  logic              SL,
  output logic [3:0]        status,
  input  logic [3:0]        cond,
  output logic              cond_true
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs_q [NumRegs];
  logic [3:0]        status_q;
  logic              wr_en;

  assign wr_en = W && (DA != ZeroAddr);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
      status_q <= 4'b0000;
    end else begin
      if (wr_en) begin
        regs_q[DA] <= D;
      end
      if (SL) begin
        status_q <= status_in;
      end
    end
  end

  // Zero register wins over bypass; bypass wins over stored contents.
  always_comb begin
    A = '0;
    if (SA != ZeroAddr) begin
      A = (wr_en && (SA == DA)) ? D : regs_q[SA];
    end
  end

  always_comb begin
    B = '0;
    if (SB != ZeroAddr) begin
      B = (wr_en && (SB == DA)) ? D : regs_q[SB];
    end
  end

  assign status = status_q;

  logic flag_v, flag_c, flag_n, flag_z;
  assign {flag_v, flag_c, flag_n, flag_z} = status_q;

  always_comb begin
    cond_true = 1'b1;
    case (cond)
      4'd0:    cond_true = flag_z;
      4'd1:    cond_true = !flag_z;
      4'd2:    cond_true = flag_c;
      4'd3:    cond_true = !flag_c;
      4'd4:    cond_true = flag_n;
      4'd5:    cond_true = !flag_n;
      4'd6:    cond_true = flag_v;
      4'd7:    cond_true = !flag_v;
      4'd8:    cond_true = flag_c && !flag_z;
      4'd9:    cond_true = !(flag_c && !flag_z);
      4'd10:   cond_true = (flag_n == flag_v);
      4'd11:   cond_true = (flag_n != flag_v);
      4'd12:   cond_true = !flag_z && (flag_n == flag_v);
      4'd13:   cond_true = !(!flag_z && (flag_n == flag_v));
      default: cond_true = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_legv8_regfile.sv
// Self-checking bench for legv8_regfile: directed plan plus randomized traffic
// compared against an array-based reference model.
module tb_legv8_regfile;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  SA, SB, DA;
  logic [63:0] D;
  logic        W;
  logic [63:0] A, B;
  logic [3:0]  status_in;
  logic        SL;
  logic [3:0]  status;
  logic [3:0]  cond;
  logic        cond_true;

  int checks   = 0;
  int failures = 0;

  logic [63:0] mdl [32];
  logic [3:0]  mdl_st;

  legv8_regfile dut (
    .clock     (clock),
    .reset     (reset),
    .SA        (SA),
    .SB        (SB),
    .DA        (DA),
    .D         (D),
    .W         (W),
    .A         (A),
    .B         (B),
    .status_in (status_in),
    .SL        (SL),
    .status    (status),
    .cond      (cond),
    .cond_true (cond_true)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Value a read port should show this cycle, from the architectural rules.
  function automatic logic [63:0] mdl_read(input logic [4:0] addr);
    if (addr == 5'd31) return 64'd0;
    if (W && DA != 5'd31 && addr == DA) return D;
    return mdl[addr];
  endfunction

  function automatic logic mdl_cond(input logic [3:0] st, input logic [3:0] cc);
    logic v, c, n, z;
    logic r;
    {v, c, n, z} = st;
    case (cc)
      4'd0:  r = z;
      4'd1:  r = !z;
      4'd2:  r = c;
      4'd3:  r = !c;
      4'd4:  r = n;
      4'd5:  r = !n;
      4'd6:  r = v;
      4'd7:  r = !v;
      4'd8:  r = c & !z;
      4'd9:  r = !(c & !z);
      4'd10: r = (n == v);
      4'd11: r = (n != v);
      4'd12: r = !z & (n == v);
      4'd13: r = !(!z & (n == v));
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
      mdl_st = 4'b0000;
    end else begin
      if (W && DA != 5'd31) mdl[DA] = D;
      if (SL) mdl_st = status_in;
    end
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; W = 1'b0; SL = 1'b0;
  endtask

  task automatic check_cond(input string tag, input logic [3:0] cc, input logic exp);
    cond = cc;
    #1;
    check(tag, {63'd0, cond_true}, {63'd0, exp});
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      SA = 5'(i);
      SB = 5'(31 - i);
      #1;
      check({tag, "_A"}, A, mdl_read(SA));
      check({tag, "_B"}, B, mdl_read(SB));
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 64'hX;
    mdl_st = 4'hX;
    SA = 0; SB = 0; DA = 0; D = 0; status_in = 0; cond = 0;
    W = 1'b0; SL = 1'b0; reset = 1'b1;
    tick();
    tick();
    idle();

    // Reset clears a previously written register and the flags.
    W = 1'b1; DA = 5'd5; D = 64'hDEAD_BEEF;
    tick();
    W = 1'b0; reset = 1'b1;
    tick();
    idle();
    SA = 5'd5;
    #1;
    check("reset_x5", A, 64'd0);
    check("reset_status", {60'd0, status}, 64'd0);
    check_cond("reset_ne", 4'd1, 1'b1);
    check_cond("reset_eq", 4'd0, 1'b0);
    check_cond("reset_al", 4'd14, 1'b1);

    // Write / read on both ports.
    W = 1'b1; DA = 5'd3; D = 64'h0123_4567_89AB_CDEF;
    tick();
    DA = 5'd30; D = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    idle();
    SA = 5'd3; SB = 5'd30;
    #1;
    check("rd_x3", A, 64'h0123_4567_89AB_CDEF);
    check("rd_x30", B, 64'hFFFF_FFFF_FFFF_FFFF);
    SB = 5'd3;
    #1;
    check("rd_same_A", A, 64'h0123_4567_89AB_CDEF);
    check("rd_same_B", B, 64'h0123_4567_89AB_CDEF);

    // XZR ignores writes and never bypasses.
    W = 1'b1; DA = 5'd31; D = 64'h55; SA = 5'd31;
    #1;
    check("xzr_pre", A, 64'd0);
    tick();
    W = 1'b0;
    #1;
    check("xzr_post", A, 64'd0);
    sweep("xzr_sweep");

    // Write-through bypass on port A only.
    W = 1'b1; DA = 5'd7; D = 64'h10;
    tick();
    W = 1'b1; DA = 5'd7; D = 64'h20; SA = 5'd7; SB = 5'd8;
    #1;
    check("byp_pre", A, 64'h20);
    check("byp_other", B, 64'd0);
    tick();
    W = 1'b0;
    #1;
    check("byp_post", A, 64'h20);

    // Status load, hold and condition evaluation.
    SL = 1'b1; status_in = 4'b0010;
    tick();
    SL = 1'b0;
    check_cond("n_lt", 4'd11, 1'b1);
    check_cond("n_ge", 4'd10, 1'b0);
    check_cond("n_mi", 4'd4, 1'b1);
    status_in = 4'b0001;
    tick();
    check("st_hold", {60'd0, status}, {60'd0, 4'b0010});
    SL = 1'b1; status_in = 4'b0101;
    tick();
    SL = 1'b0;
    check_cond("cz_eq", 4'd0, 1'b1);
    check_cond("cz_hi", 4'd8, 1'b0);
    check_cond("cz_ls", 4'd9, 1'b1);
    check_cond("cz_gt", 4'd12, 1'b0);
    check_cond("cz_al", 4'd15, 1'b1);

    // Reset beats a simultaneous write and status load.
    reset = 1'b1; W = 1'b1; DA = 5'd2; D = 64'h99; SL = 1'b1; status_in = 4'b1111;
    tick();
    idle();
    SA = 5'd2;
    #1;
    check("rprio_x2", A, 64'd0);
    check("rprio_status", {60'd0, status}, 64'd0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 39) == 0);
      W         = 1'($urandom_range(0, 1));
      SL        = 1'($urandom_range(0, 1));
      DA        = 5'($urandom_range(0, 31));
      D         = {$urandom, $urandom};
      status_in = 4'($urandom_range(0, 15));
      cond      = 4'($urandom_range(0, 15));
      SA        = ($urandom_range(0, 3) == 0) ? DA : 5'($urandom_range(0, 31));
      SB        = ($urandom_range(0, 3) == 0) ? DA : 5'($urandom_range(0, 31));
      #1;
      check("rnd_A", A, mdl_read(SA));
      check("rnd_B", B, mdl_read(SB));
      check("rnd_status", {60'd0, status}, {60'd0, mdl_st});
      check("rnd_cond", {63'd0, cond_true}, {63'd0, mdl_cond(mdl_st, cond)});
      tick();
    end
    idle();
    sweep("final_sweep");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
